// File: rtl/ace_snoop_collector.sv
// ACE snoop fan-out / CRRESP merge: broadcasts one snoop to a mask of masters and merges their responses.
// Optional CR timeout with orphan draining is enabled by defining ACE_SNOOP_COLLECTOR_TIMEOUT_EN.
module ace_snoop_collector #(
  parameter int NoMst         = 4,
  parameter int AddrWidth     = 64,
  parameter int TimeoutCycles = 1024,
  localparam int SrcW         = $clog2(NoMst)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AddrWidth-1:0]       req_addr_i,
  input  logic [3:0]                 req_snoop_i,
  input  logic [2:0]                 req_prot_i,
  input  logic [NoMst-1:0]           req_mask_i,
  output logic [NoMst-1:0]           ac_valid_o,
  input  logic [NoMst-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]       ac_addr_o,
  output logic [3:0]                 ac_snoop_o,
  output logic [2:0]                 ac_prot_o,
  input  logic [NoMst-1:0]           cr_valid_i,
  output logic [NoMst-1:0]           cr_ready_o,
  input  logic [NoMst-1:0][4:0]      cr_resp_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [4:0]                 rsp_resp_o,
  output logic [SrcW-1:0]            rsp_data_src_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BCAST, ST_RESP} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [3:0]             snoop_q;
  logic [2:0]             prot_q;
  logic [NoMst-1:0]       mask_q, ac_done_q, cr_done_q, dt_q;
  logic [4:0]             acc_q;
  logic [SrcW-1:0]        src_q;

  logic [NoMst-1:0]       ac_hs, cr_hs, cr_ready_bc, ac_done_d, cr_done_d, dt_d, orphan_w;
  logic [4:0]             acc_d;
  logic [SrcW-1:0]        src_d;
  logic                   tmo_hit;

  assign ac_valid_o     = (state_q == ST_BCAST) ? (mask_q & ~ac_done_q) : '0;
  assign cr_ready_bc    = (state_q == ST_BCAST) ? (mask_q & ac_done_q & ~cr_done_q) : '0;
  assign cr_ready_o     = cr_ready_bc | orphan_w;
  assign req_ready_o    = (state_q == ST_IDLE) && (orphan_w == '0);
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign ac_addr_o      = addr_q;
  assign ac_snoop_o     = snoop_q;
  assign ac_prot_o      = prot_q;
  assign rsp_resp_o     = acc_q;
  assign rsp_data_src_o = src_q;

  assign ac_hs     = ac_valid_o & ac_ready_i;
  assign cr_hs     = cr_valid_i & cr_ready_bc;
  assign ac_done_d = ac_done_q | ac_hs;
  assign cr_done_d = cr_done_q | cr_hs;

  // Data source is the lowest-index supplier overall, not the first one in time.
  always_comb begin
    acc_d = acc_q;
    dt_d  = dt_q;
    for (int i = 0; i < NoMst; i++) begin
      if (cr_hs[i]) begin
        acc_d    = acc_d | cr_resp_i[i];
        dt_d[i]  = dt_q[i] | cr_resp_i[i][0];
      end
    end
    src_d = '0;
    for (int i = NoMst - 1; i >= 0; i--) begin
      if (dt_d[i]) src_d = SrcW'(i);
    end
  end

`ifdef ACE_SNOOP_COLLECTOR_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [NoMst-1:0] orphan_q;

  // Silence is counted from the cycle the last AC handshake completes.
  always_comb begin
    tmo_d = '0;
    if ((ac_done_d & mask_q) == mask_q) tmo_d = (|cr_hs) ? '0 : tmo_q + 1'b1;
  end
  assign tmo_hit  = (state_q == ST_BCAST) && (tmo_d == TmoW'(TimeoutCycles));
  assign orphan_w = orphan_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q    <= '0;
      orphan_q <= '0;
    end else begin
      tmo_q <= (state_q == ST_BCAST) ? tmo_d : '0;
      if (tmo_hit) orphan_q <= mask_q & ~cr_done_d;
      else         orphan_q <= orphan_q & ~cr_valid_i;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign orphan_w = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      dt_q      <= '0;
      acc_q     <= '0;
      src_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            addr_q    <= req_addr_i;
            snoop_q   <= req_snoop_i;
            prot_q    <= req_prot_i;
            mask_q    <= req_mask_i;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            acc_q     <= '0;
            src_q     <= '0;
            state_q   <= (req_mask_i != '0) ? ST_BCAST : ST_RESP;
          end
        end
        ST_BCAST: begin
          ac_done_q <= ac_done_d;
          cr_done_q <= cr_done_d;
          dt_q      <= dt_d;
          acc_q     <= acc_d;
          src_q     <= src_d;
          if (cr_done_d == mask_q) begin
            state_q <= ST_RESP;
          end else if (tmo_hit) begin
            acc_q   <= acc_d | 5'b00010;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// Self-checking bench for ace_snoop_collector: directed table, reset/timeout sequences, random vs. reference model.
module tb_ace_snoop_collector;
  localparam int NM = 4;
  localparam int AW = 64;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                req_valid_i, req_ready_o;
  logic [AW-1:0]       req_addr_i;
  logic [3:0]          req_snoop_i;
  logic [2:0]          req_prot_i;
  logic [NM-1:0]       req_mask_i;
  logic [NM-1:0]       ac_valid_o, ac_ready_i;
  logic [AW-1:0]       ac_addr_o;
  logic [3:0]          ac_snoop_o;
  logic [2:0]          ac_prot_o;
  logic [NM-1:0]       cr_valid_i, cr_ready_o;
  logic [NM-1:0][4:0]  cr_resp_i;
  logic                rsp_valid_o, rsp_ready_i;
  logic [4:0]          rsp_resp_o;
  logic [1:0]          rsp_data_src_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ace_snoop_collector #(.NoMst(NM), .AddrWidth(AW), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_snoop_i(req_snoop_i), .req_prot_i(req_prot_i), .req_mask_i(req_mask_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
    .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_resp_o(rsp_resp_o), .rsp_data_src_o(rsp_data_src_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_ac_valid"},  64'(ac_valid_o), 64'd0);
    chk({tag, "_cr_ready"},  64'(cr_ready_o), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_ac_payload"}, 64'(ac_addr_o) | 64'(ac_snoop_o) | 64'(ac_prot_o), 64'd0);
    chk({tag, "_rsp_resp"},  64'(rsp_resp_o), 64'd0);
    chk({tag, "_rsp_src"},   64'(rsp_data_src_o), 64'd0);
  endtask

  // mode 0: all ready immediately; 1: random masters; 2: master 1 AC delayed with early CR valid
  task automatic run_snoop(input logic [3:0] mask, input logic [3:0] snoop, input logic [3:0][4:0] r,
                           input int mode, input int hold,
                           output int lat, output logic [4:0] got_resp, output logic [1:0] got_src);
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [3:0]    ac_done, cr_done, hs_cr;
    int            ac_cyc[4];
    int            cyc, last_cr, viol, hold_bad;
    addr = {$urandom, $urandom};
    prot = 3'($urandom);
    ac_done = '0; cr_done = '0; viol = 0; hold_bad = 0; last_cr = 0;
    for (int i = 0; i < 4; i++) ac_cyc[i] = 0;
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_snoop_i = snoop; req_prot_i = prot; req_mask_i = mask;
    cr_resp_i = r; rsp_ready_i = 1'b0; ac_ready_i = '0; cr_valid_i = '0;
    @(negedge clk);
    req_valid_i = 1'b0; req_addr_i = ~addr; req_snoop_i = ~snoop; req_mask_i = ~mask;
    cyc = 1;
    chk("ac_valid_T1", 64'(ac_valid_o), 64'(mask));
    while (!rsp_valid_o && cyc < 200) begin
      if (req_ready_o !== 1'b0) viol++;
      if (ac_valid_o !== (mask & ~ac_done)) viol++;
      if (cr_ready_o !== (mask & ac_done & ~cr_done)) viol++;
      if (ac_addr_o !== addr || ac_snoop_o !== snoop || ac_prot_o !== prot) viol++;
      case (mode)
        0: begin ac_ready_i = '1; cr_valid_i = mask; end
        2: begin ac_ready_i = (cyc >= 4) ? 4'b1111 : 4'b1101; cr_valid_i = mask; end
        default: begin
          ac_ready_i = 4'($urandom);
          for (int i = 0; i < 4; i++) begin
            if (!mask[i])        cr_valid_i[i] = 1'($urandom);
            else if (cr_done[i]) cr_valid_i[i] = 1'b0;
            else if (!cr_valid_i[i])
              cr_valid_i[i] = (ac_done[i] && (cyc - ac_cyc[i] >= 3)) || ($urandom_range(2) == 0);
          end
        end
      endcase
      for (int i = 0; i < 4; i++) if (ac_valid_o[i] && ac_ready_i[i]) begin ac_done[i] = 1'b1; ac_cyc[i] = cyc; end
      hs_cr = cr_valid_i & cr_ready_o & mask & ~cr_done;
      if (hs_cr != '0) begin cr_done = cr_done | hs_cr; last_cr = cyc; end
      @(negedge clk);
      cyc++;
    end
    ac_ready_i = '0; cr_valid_i = '0;
    chk("rsp_wait_bound", 64'(cyc < 200), 64'd1);
    chk("protocol_rules_violations", 64'(viol), 64'd0);
    chk("all_cr_collected", 64'(cr_done), 64'(mask));
    chk("rsp_after_last_cr", 64'(cyc), 64'(last_cr + 1));
    lat = cyc; got_resp = rsp_resp_o; got_src = rsp_data_src_o;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!rsp_valid_o || rsp_resp_o !== got_resp || rsp_data_src_o !== got_src || req_ready_o) hold_bad++;
    end
    chk("rsp_hold_stable", 64'(hold_bad), 64'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_single_hs", 64'(rsp_valid_o), 64'd0);
    chk("req_ready_after_rsp", 64'(req_ready_o), 64'd1);
  endtask

  typedef struct {
    logic [3:0]      mask;
    logic [3:0]      snoop;
    logic [3:0][4:0] r;
    int              mode;
    int              hold;
    logic [4:0]      exp_resp;
    logic [1:0]      exp_src;
    int              exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int         lat;
    logic [4:0] got_resp, exp_resp;
    logic [1:0] got_src, exp_src;
    logic [3:0] mask;
    logic [3:0][4:0] r;
    bit         found;

    tbl[0] = '{4'b0110, 4'b0001, {5'b00000, 5'b01001, 5'b01000, 5'b00000}, 0, 0, 5'b01001, 2'd2, 3};
    tbl[1] = '{4'b0000, 4'b1111, {5'b11111, 5'b11111, 5'b11111, 5'b11111}, 0, 0, 5'b00000, 2'd0, 1};
    tbl[2] = '{4'b1111, 4'b0001, {5'b00101, 5'b00001, 5'b00001, 5'b00001}, 0, 0, 5'b00101, 2'd0, 3};
    tbl[3] = '{4'b0110, 4'b0111, {5'b00000, 5'b01001, 5'b11001, 5'b00000}, 2, 5, 5'b11001, 2'd1, 6};
    tbl[4] = '{4'b1000, 4'b0010, {5'b10011, 5'b00000, 5'b00000, 5'b00000}, 0, 0, 5'b10011, 2'd3, 3};
    tbl[5] = '{4'b0101, 4'b0000, {5'b00000, 5'b00001, 5'b00000, 5'b10000}, 0, 1, 5'b10001, 2'd2, 3};

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_snoop_i = '0; req_prot_i = '0;
    req_mask_i = '0; ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0; rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_i = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_snoop(tbl[i].mask, tbl[i].snoop, tbl[i].r, tbl[i].mode, tbl[i].hold, lat, got_resp, got_src);
      chk($sformatf("tbl%0d_resp", i), 64'(got_resp), 64'(tbl[i].exp_resp));
      chk($sformatf("tbl%0d_src", i),  64'(got_src),  64'(tbl[i].exp_src));
      chk($sformatf("tbl%0d_lat", i),  64'(lat),      64'(tbl[i].exp_lat));
    end

    // Abort a broadcast with reset, then check a fresh snoop still works.
    req_valid_i = 1'b1; req_addr_i = 64'hDEAD_BEEF_0000_1234; req_snoop_i = 4'b0001; req_mask_i = 4'b1111;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("bcast_before_rst", 64'(ac_valid_o), 64'hF);
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    run_snoop(tbl[0].mask, tbl[0].snoop, tbl[0].r, 0, 0, lat, got_resp, got_src);
    chk("post_rst_resp", 64'(got_resp), 64'(tbl[0].exp_resp));
    chk("post_rst_lat",  64'(lat), 64'd3);

`ifdef ACE_SNOOP_COLLECTOR_TIMEOUT_EN
    begin
      int n;
      req_valid_i = 1'b1; req_snoop_i = 4'b0001; req_mask_i = 4'b1000; ac_ready_i = '1; cr_valid_i = '0;
      cr_resp_i = '0;
      @(negedge clk);
      req_valid_i = 1'b0;
      n = 1;
      while (!rsp_valid_o && n < 40) begin @(negedge clk); n++; end
      chk("tmo_latency", 64'(n), 64'd9);
      chk("tmo_resp_error", 64'(rsp_resp_o), 64'b00010);
      ac_ready_i = '0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      chk("tmo_rsp_done", 64'(rsp_valid_o), 64'd0);
      chk("tmo_req_blocked", 64'(req_ready_o), 64'd0);
      chk("tmo_orphan_ready", 64'(cr_ready_o), 64'h8);
      repeat (2) @(negedge clk);
      chk("tmo_still_blocked", 64'(req_ready_o), 64'd0);
      cr_valid_i = 4'b1000;
      @(negedge clk);
      cr_valid_i = '0;
      chk("tmo_drained_ready", 64'(req_ready_o), 64'd1);
      chk("tmo_drained_cr", 64'(cr_ready_o), 64'd0);
    end
`endif

    // Random traffic against a reference: OR of masked responses, lowest masked supplier.
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom);
      r = 20'($urandom);
      exp_resp = '0; exp_src = '0; found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          exp_resp = exp_resp | r[i];
          if (r[i][0] && !found) begin exp_src = 2'(i); found = 1'b1; end
        end
      end
      run_snoop(mask, 4'($urandom), r, 1, $urandom_range(3), lat, got_resp, got_src);
      chk($sformatf("rnd%0d_resp", t), 64'(got_resp), 64'(exp_resp));
      chk($sformatf("rnd%0d_src", t),  64'(got_src),  64'(exp_src));
      if (mask == '0) chk($sformatf("rnd%0d_empty_lat", t), 64'(lat), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
